// File: rtl/constant_sequencer_pkg.sv
// Shared types and helpers for the constant sequencer: the FSM state encoding
// and the index-width function used by the top and by the table.
package constant_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // A one-entry table still needs a one-bit index port.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/constant_sequencer_table.sv
// Table storage for constant_sequencer. With CONSTANT_SEQUENCER_WRITE_EN the
// entries are registers reloaded from VALUES on reset; otherwise they are constants.
module constant_sequencer_table
  import constant_sequencer_pkg::*;
#(
  parameter int                          WORD_WIDTH = 32,
  parameter int                          DEPTH      = 4,
  parameter logic [WORD_WIDTH*DEPTH-1:0] VALUES     = '0,
  parameter int                          IDX_W      = idx_width(DEPTH)
) (
`ifdef CONSTANT_SEQUENCER_WRITE_EN
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  write_en,
  input  logic [IDX_W-1:0]      write_index,
  input  logic [WORD_WIDTH-1:0] write_data,
`endif
  input  logic [IDX_W-1:0]      index,
  output logic [WORD_WIDTH-1:0] data
);

  logic [WORD_WIDTH-1:0] table_s [DEPTH];

`ifdef CONSTANT_SEQUENCER_WRITE_EN
  logic [WORD_WIDTH-1:0] mem_r [DEPTH];

  // Storage: reload from VALUES on reset; out-of-range indices match no entry.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= VALUES[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (write_en && (write_index == IDX_W'(i))) begin
          mem_r[i] <= write_data;
        end
      end
    end
  end

  assign table_s = mem_r;
`else
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign table_s[gi] = VALUES[gi*WORD_WIDTH +: WORD_WIDTH];
  end
`endif

  // Combinational read as a one-hot OR so any index width is safe.
  always_comb begin
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      data = data | ({WORD_WIDTH{index == IDX_W'(i)}} & table_s[i]);
    end
  end

endmodule

// File: rtl/constant_sequencer.sv
// Streams a constant table once per start over a valid/ready port.
// Optional runtime table writes are enabled by macro CONSTANT_SEQUENCER_WRITE_EN.
module constant_sequencer
  import constant_sequencer_pkg::*;
#(
  parameter int                          WORD_WIDTH = 32,
  parameter int                          DEPTH      = 4,
  parameter logic [WORD_WIDTH*DEPTH-1:0] VALUES     = '0,
  parameter bit                          AUTO_START = 1'b1,
  parameter int                          IDX_W      = idx_width(DEPTH)
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
`ifdef CONSTANT_SEQUENCER_WRITE_EN
  input  logic                  write_valid,
  input  logic [IDX_W-1:0]      write_index,
  input  logic [WORD_WIDTH-1:0] write_data,
  output logic                  write_ready,
`endif
  output logic [IDX_W-1:0]      out_index
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  seq_state_e       state_r;
  logic [IDX_W-1:0] index_r;
  logic             auto_r;

  // Sequencer FSM; auto_r arms exactly one automatic start after reset release.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_r <= ST_IDLE;
      index_r <= '0;
      auto_r  <= AUTO_START;
    end else begin
      auto_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start || auto_r) begin
            state_r <= ST_SEND;
            index_r <= '0;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (index_r == LAST_IDX) begin
              state_r <= ST_DONE;
              index_r <= '0;
            end else begin
              index_r <= index_r + IDX_W'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          index_r <= '0;
        end
      endcase
    end
  end

  assign busy      = (state_r == ST_SEND);
  assign done      = (state_r == ST_DONE);
  assign out_valid = (state_r == ST_SEND);
  assign out_index = index_r;

`ifdef CONSTANT_SEQUENCER_WRITE_EN
  assign write_ready = !busy;
`endif

  constant_sequencer_table #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .VALUES     (VALUES),
    .IDX_W      (IDX_W)
  ) u_table (
`ifdef CONSTANT_SEQUENCER_WRITE_EN
    .clock       (clock),
    .clear_n     (clear_n),
    .write_en    (write_valid && write_ready),
    .write_index (write_index),
    .write_data  (write_data),
`endif
    .index       (index_r),
    .data        (out_data)
  );

endmodule
